// File: rtl/doitgen_aout_unpacker_if.sv
// doitgen_aout_unpacker_if
//   Stream bundle between a packed-word producer, the unpacker and an
//   element consumer.
//   in_*  : packed word channel (valid/ready), lane 0 in the MSB byte.
//   out_* : unpacked element channel (valid/ready) with (r,q,p) tag and
//           end-of-frame marker.
//   master : the environment side (drives words, accepts elements).
//   slave  : the unpacker side.
interface doitgen_aout_unpacker_if #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int DIM_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [DIM_W-1:0]  out_r;
  logic [DIM_W-1:0]  out_q;
  logic [DIM_W-1:0]  out_p;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_r, out_q, out_p, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_r, out_q, out_p, out_last
  );
endinterface

// File: rtl/doitgen_aout_unpacker.sv
// doitgen_aout_unpacker
//   Receiver-side drain for the doitgen result stream. Accepts packed
//   DATA_W-bit Aout words and emits their four LANE_W-bit elements one per
//   handshake, tagged with (r,q,p), for a frame of nr*nq*np elements.
//   Lanes of the final word beyond the last element are dropped.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : one-cycle frame start, honoured only when idle
//   nr, nq, np    : frame dimensions, latched on accepted start
//   bus (slave)   : in_* word channel and out_* element channel
//   busy          : frame in progress
//   done          : one-cycle pulse at frame completion
//   checksum      : (AOUT_CHECKSUM_EN only) mod-2^16 sum of accepted
//                   elements, valid from done until the next start
//
// Build option
//   AOUT_CHECKSUM_EN : adds the checksum port and accumulator.
module doitgen_aout_unpacker #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int DIM_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] nr,
  input  logic [DIM_W-1:0] nq,
  input  logic [DIM_W-1:0] np,
  doitgen_aout_unpacker_if.slave bus,
  output logic             busy,
`ifdef AOUT_CHECKSUM_EN
  output logic             done,
  output logic [15:0]      checksum
`else
  output logic             done
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [1:0]        state;
  logic [DIM_W-1:0]  nr_l, nq_l, np_l;
  logic [DIM_W-1:0]  r, q, p;
  logic [1:0]        lane;
  logic [DATA_W-1:0] word;

  logic p_wrap, q_wrap, at_last, emit_fire;

  assign p_wrap    = (p == np_l - ONE);
  assign q_wrap    = (q == nq_l - ONE);
  assign at_last   = (r == nr_l - ONE) && q_wrap && p_wrap;
  assign emit_fire = (state == EMIT) && bus.out_ready;

  assign bus.in_ready  = (state == RECV);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_last  = (state == EMIT) && at_last;
  assign bus.out_r     = r;
  assign bus.out_q     = q;
  assign bus.out_p     = p;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // Lane 0 occupies the most-significant byte of the held word.
  always_comb begin
    bus.out_data = '0;
    case (lane)
      2'd0:    bus.out_data = word[4*LANE_W-1 -: LANE_W];
      2'd1:    bus.out_data = word[3*LANE_W-1 -: LANE_W];
      2'd2:    bus.out_data = word[2*LANE_W-1 -: LANE_W];
      default: bus.out_data = word[LANE_W-1 -: LANE_W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      nr_l  <= '0;
      nq_l  <= '0;
      np_l  <= '0;
      r     <= '0;
      q     <= '0;
      p     <= '0;
      lane  <= '0;
      word  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nr_l <= nr;
            nq_l <= nq;
            np_l <= np;
            r    <= '0;
            q    <= '0;
            p    <= '0;
            lane <= '0;
            if (nr == '0 || nq == '0 || np == '0) state <= DONE;
            else                                  state <= RECV;
          end
        end
        RECV: begin
          if (bus.in_valid) begin
            word  <= bus.in_data;
            lane  <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            // p innermost, then q, then r; r may step to nr on the final
            // element, which is harmless since the frame ends there.
            if (p_wrap) begin
              p <= '0;
              if (q_wrap) begin
                q <= '0;
                r <= r + ONE;
              end else begin
                q <= q + ONE;
              end
            end else begin
              p <= p + ONE;
            end
            if (at_last)           state <= DONE;
            else if (lane == 2'd3) state <= RECV;
            else                   lane  <= lane + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AOUT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      checksum <= '0;
    else if (state == IDLE && start)
      checksum <= '0;
    else if (emit_fire)
      checksum <= checksum + 16'(bus.out_data);
  end
`endif

endmodule
